// File: rtl/pong_pkg.sv
// Shared constants and types for the pong renderers: segment indices,
// unscaled seven-segment glyph geometry and the BCD digit type.
package pong_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int SEG_THICK = 5;
  localparam int SEG_LEN   = 16;
  localparam int CELL_W    = 26;
  localparam int CELL_H    = 39;

  typedef logic [3:0] bcd_t;

  // Half-open interval test [lo, hi) on an 11-bit cell coordinate.
  function automatic logic in_span(input logic [10:0] v, input int lo, input int hi);
    return (v >= 11'(lo)) && (v < 11'(hi));
  endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD to seven-segment decoder, active-high segments a..g
// on bits SEG_A..SEG_G; codes 10..15 decode to blank.
module bcd_seg7_decode
  import pong_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Bit order {g,f,e,d,c,b,a}.
  always_comb begin
    // NOTE: default first so every path assigns seg and no latch is inferred.
    seg = 7'b000_0000;
    unique case (bcd)
      4'd0:    seg = 7'b011_1111;
      4'd1:    seg = 7'b000_0110;
      4'd2:    seg = 7'b101_1011;
      4'd3:    seg = 7'b100_1111;
      4'd4:    seg = 7'b110_0110;
      4'd5:    seg = 7'b110_1101;
      4'd6:    seg = 7'b111_1101;
      4'd7:    seg = 7'b000_0111;
      4'd8:    seg = 7'b111_1111;
      4'd9:    seg = 7'b110_1111;
      default: seg = 7'b000_0000;
    endcase
  end

endmodule

// File: rtl/score_seg_renderer.sv
// Saturating BCD score counter plus a 2-stage pixel pipeline that draws the
// score as scaled seven-segment digits. Optional blink-on-change: SCORE_FLASH_EN.
module score_seg_renderer
  import pong_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int SCALE        = 1,
  parameter int DIGIT_GAP    = 8,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          start_x,
  input  logic [9:0]          start_y,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                pix_valid_in,
  input  logic                score_inc,
  input  logic                score_clr,
  input  logic                frame_tick,
  output logic [4*DIGITS-1:0] score,
  output logic                max_reached,
  output logic                pix_valid_out,
  output logic                display
);

  localparam int CW    = CELL_W * SCALE;
  localparam int CH    = CELL_H * SCALE;
  localparam int PITCH = CW + DIGIT_GAP;
  localparam int T     = SEG_THICK * SCALE;
  localparam int L     = SEG_LEN * SCALE;
  localparam int Y_MID = 17 * SCALE;
  localparam int Y_LOW = 22 * SCALE;
  localparam int Y_BOT = 34 * SCALE;

  // ---------------- score counter ----------------
  logic [4*DIGITS-1:0] score_q, score_d;
  logic                max_q, max_d;
  logic                carry;

  always_comb begin
    score_d = score_q;
    carry   = 1'b1;
    if (score_clr) begin
      score_d = '0;
    end else if (score_inc && !max_q) begin
      // Low nibble is the LSD; ripple the decimal carry toward digit 0.
      for (int j = 0; j < DIGITS; j++) begin
        if (carry) begin
          if (score_q[4*j +: 4] == 4'd9) begin
            score_d[4*j +: 4] = 4'd0;
          end else begin
            score_d[4*j +: 4] = score_q[4*j +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
    max_d = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (score_d[4*j +: 4] != 4'd9) max_d = 1'b0;
    end
  end

  // ---------------- stage 1: locate cell ----------------
  logic [10:0] dx, dy, rem;
  logic        found;
  logic        in_box1_d, in_box1_q;
  logic [10:0] cx_d, cx_q, cy_d, cy_q;
  bcd_t        nib_d, nib_q;
  logic        valid1_q;

  always_comb begin
    dx        = {1'b0, x} - {1'b0, start_x};
    dy        = {1'b0, y} - {1'b0, start_y};
    // NOTE: blocking assignments here model a combinational chain; rem is
    // rewritten step by step within one evaluation.
    rem       = dx;
    found     = 1'b0;
    in_box1_d = 1'b0;
    cx_d      = '0;
    cy_d      = dy;
    nib_d     = '0;
    if (!dx[10] && !dy[10] && (dy < 11'(CH))) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (!found) begin
          if (rem < 11'(CW)) begin
            in_box1_d = 1'b1;
            cx_d      = rem;
            nib_d     = score_q[4*(DIGITS-1-i) +: 4];
            found     = 1'b1;
          end else if (rem < 11'(PITCH)) begin
            found = 1'b1;  // inter-digit gap
          end else begin
            rem = rem - 11'(PITCH);
          end
        end
      end
    end
  end

  // ---------------- stage 2: segment hit ----------------
  logic [6:0] seg_lit, seg_hit;
  logic       blank;
  logic       display_d, display_q;
  logic       valid2_q;

  bcd_seg7_decode u_decode (
    .bcd (nib_q),
    .seg (seg_lit)
  );

  always_comb begin
    seg_hit        = '0;
    seg_hit[SEG_A] = in_span(cx_q, T, T + L)   && in_span(cy_q, 0, T);
    seg_hit[SEG_B] = in_span(cx_q, T + L, CW)  && in_span(cy_q, T, Y_MID);
    seg_hit[SEG_C] = in_span(cx_q, T + L, CW)  && in_span(cy_q, Y_LOW, Y_BOT);
    seg_hit[SEG_D] = in_span(cx_q, T, T + L)   && in_span(cy_q, Y_BOT, CH);
    seg_hit[SEG_E] = in_span(cx_q, 0, T)       && in_span(cy_q, Y_LOW, Y_BOT);
    seg_hit[SEG_F] = in_span(cx_q, 0, T)       && in_span(cy_q, T, Y_MID);
    seg_hit[SEG_G] = in_span(cx_q, T, T + L)   && in_span(cy_q, Y_MID, Y_LOW);
    display_d      = (|(seg_hit & seg_lit)) && in_box1_q && valid1_q && !blank;
  end

`ifdef SCORE_FLASH_EN
  localparam int FW = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);

  logic [FW-1:0] flash_q, flash_d;
  logic          score_changed;

  always_comb begin
    score_changed = score_clr || (score_inc && !max_q);
    flash_d       = flash_q;
    if (score_changed) begin
      flash_d = FW'(FLASH_FRAMES);
    end else if (frame_tick && (flash_q != '0)) begin
      flash_d = flash_q - FW'(1);
    end
    blank = (flash_q != '0) && flash_q[2];
  end

  always_ff @(posedge clk) begin
    if (reset) flash_q <= '0;
    else       flash_q <= flash_d;
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign blank             = 1'b0;
`endif

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      score_q   <= '0;
      max_q     <= 1'b0;
      in_box1_q <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      nib_q     <= '0;
      valid1_q  <= 1'b0;
      valid2_q  <= 1'b0;
      display_q <= 1'b0;
    end else begin
      score_q   <= score_d;
      max_q     <= max_d;
      in_box1_q <= in_box1_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      nib_q     <= nib_d;
      valid1_q  <= pix_valid_in;
      valid2_q  <= valid1_q;
      display_q <= display_d;
    end
  end

  assign score         = score_q;
  assign max_reached   = max_q;
  assign pix_valid_out = valid2_q;
  assign display       = display_q;

endmodule

// File: tb/tb_score_seg_renderer.sv
// Directed self-checking bench for score_seg_renderer (DIGITS=2, SCALE=1);
// the blink section runs only when SCORE_FLASH_EN is defined.
module tb_score_seg_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] start_x, start_y, x, y;
  logic       pix_valid_in, score_inc, score_clr, frame_tick;
  logic [7:0] score;
  logic       max_reached, pix_valid_out, display;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SCORE_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  always #5 clk = ~clk;

  score_seg_renderer dut (
    .clk           (clk),
    .reset         (reset),
    .start_x       (start_x),
    .start_y       (start_y),
    .x             (x),
    .y             (y),
    .pix_valid_in  (pix_valid_in),
    .score_inc     (score_inc),
    .score_clr     (score_clr),
    .frame_tick    (frame_tick),
    .score         (score),
    .max_reached   (max_reached),
    .pix_valid_out (pix_valid_out),
    .display       (display)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel for one cycle; result is sampled 2 clocks later.
  task automatic pixel(input string tag, input int px, input int py, input logic v,
                       input logic exp, input bit chk_lat);
    @(negedge clk);
    x = 10'(px); y = 10'(py); pix_valid_in = v;
    @(negedge clk);
    pix_valid_in = 1'b0;
    if (chk_lat) begin
      check({tag, "_lat1_valid"}, 32'(pix_valid_out), 32'd0);
      check({tag, "_lat1_disp"},  32'(display),       32'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(pix_valid_out), 32'(v));
    check(tag,             32'(display),       32'(exp));
  endtask

  task automatic pulse_inc();
    @(negedge clk); score_inc = 1'b1;
    @(negedge clk); score_inc = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_x = 10'd100; start_y = 10'd50; x = '0; y = '0;
    pix_valid_in = 1'b0; score_inc = 1'b0; score_clr = 1'b0; frame_tick = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_score", 32'(score),         32'h00);
    check("rst_max",   32'(max_reached),   32'd0);
    check("rst_disp",  32'(display),       32'd0);
    check("rst_pvo",   32'(pix_valid_out), 32'd0);
    reset = 1'b0;

    // Score 00 glyphs
    pixel("d0_seg_a",      105, 50, 1'b1, 1'b1, 1'b1);
    pixel("d0_seg_g_off",  110, 69, 1'b1, 1'b0, 1'b0);
    pixel("d1_seg_b",      155, 55, 1'b1, 1'b1, 1'b0);
    pixel("gap",           128, 55, 1'b1, 1'b0, 1'b0);
    pixel("invalid_pix",   105, 50, 1'b0, 1'b0, 1'b0);
    pixel("below_cell",    105, 89, 1'b1, 1'b0, 1'b0);
    pixel("beyond_digits", 168, 50, 1'b1, 1'b0, 1'b0);

    // Counting
    pulse_inc();
    check("score_01", 32'(score), 32'h01);
    pixel("d1_one_seg_a", 139, 50, 1'b1, 1'b0, 1'b0);
    repeat (9) pulse_inc();
    check("score_carry_10", 32'(score), 32'h10);
    check("max_10",         32'(max_reached), 32'd0);
    repeat (89) pulse_inc();
    check("score_99", 32'(score),       32'h99);
    check("max_99",   32'(max_reached), 32'd1);
    pixel("d0_nine_seg_g", 110, 69, 1'b1, !FLASH, 1'b0);
    pulse_inc();
    check("sat_score", 32'(score),       32'h99);
    check("sat_max",   32'(max_reached), 32'd1);

    // Clear wins over increment
    @(negedge clk); score_inc = 1'b1; score_clr = 1'b1;
    @(negedge clk); score_inc = 1'b0; score_clr = 1'b0;
    check("clr_score", 32'(score),       32'h00);
    check("clr_max",   32'(max_reached), 32'd0);

    // Reset mid-pipeline flushes an in-flight lit pixel
    @(negedge clk); x = 10'd105; y = 10'd50; pix_valid_in = 1'b1;
    @(negedge clk); pix_valid_in = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("midrst_disp", 32'(display),       32'd0);
    check("midrst_pvo",  32'(pix_valid_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_disp", 32'(display), 32'd0);

    // No 10-bit wrap-around
    start_x = 10'd1000; start_y = 10'd0;
    pixel("nowrap_neg", 5,    10, 1'b1, 1'b0, 1'b0);
    pixel("nowrap_hit", 1005, 0,  1'b1, 1'b1, 1'b0);
    start_x = 10'd100; start_y = 10'd50;

`ifdef SCORE_FLASH_EN
    // Blink after a change: counter 30,29,28 blank (bit2=1), 27 shows
    pulse_inc();
    pixel("flash_30", 105, 50, 1'b1, 1'b0, 1'b0);
    repeat (2) pulse_tick();
    pixel("flash_28", 105, 50, 1'b1, 1'b0, 1'b0);
    pulse_tick();
    pixel("flash_27", 105, 50, 1'b1, 1'b1, 1'b0);
    repeat (27) pulse_tick();
    pixel("flash_done", 105, 50, 1'b1, 1'b1, 1'b0);
    repeat (6) pulse_tick();
    pixel("flash_stays", 105, 50, 1'b1, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/score_seg_renderer.md
Name: score_seg_renderer

Overview:
- Parametrised successor to the single-digit seven-segment pixel test: renders a DIGITS-wide BCD score as scaled seven-segment glyphs on the VGA raster.
- Owns the score counter (increment, clear, saturate) and a 2-stage registered pixel pipeline.
- Sits between the game-logic score events and the VGA pixel mux. `display` is OR'd into the foreground colour.

Parameters:
- DIGITS, 2, number of BCD digits; digit 0 is the most significant and leftmost.
- SCALE, 1, integer glyph scale: segment thickness 5*SCALE, segment length 16*SCALE, cell 26*SCALE x 39*SCALE.
- DIGIT_GAP, 8, horizontal pixels between adjacent digit cells.
- FLASH_FRAMES, 30, frames of flashing after a score change (used only with the optional feature).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- start_x  in  10  left edge of digit 0 cell
- start_y  in  10  top edge of all cells
- x  in  10  current raster column
- y  in  10  current raster row
- pix_valid_in  in  1  x/y qualify as an active-video pixel
- score_inc  in  1  single-cycle pulse: add 1 to score
- score_clr  in  1  single-cycle pulse: score := 0
- frame_tick  in  1  single-cycle pulse once per frame
- score  out  4*DIGITS  BCD score, digit 0 in the MSBs
- max_reached  out  1  high while all digits are 9
- pix_valid_out  out  1  pix_valid_in delayed 2 cycles
- display  out  1  pixel lies on a lit segment, aligned with pix_valid_out

Behaviour:
- Reset values: score=0, max_reached=0, pix_valid_out=0, display=0, pipeline registers=0, flash counter=0.
- Score update, effective the cycle after the pulse:
  - score_clr has priority over score_inc when both are high in the same cycle.
  - An increment ripples a decimal carry from the last digit (LSD) toward digit 0.
  - At all-9s, score_inc is ignored (saturate; no wrap).
  - max_reached is registered from the updated score.
- Pipeline latency is exactly 2 clocks, fully pipelined (one pixel per clock, no stalls).
- Stage 1:
  - Compute dx = x - start_x and dy = y - start_y in 11 bits.
  - Negative or out-of-range values give in_box=0 (no 10-bit wrap-around hits).
  - Cell pitch P = 26*SCALE + DIGIT_GAP. Digit index = dx / P, offset = dx mod P. Implement with a compare/subtract chain over DIGITS; no divider.
  - Offsets falling in the gap, or digit index >= DIGITS, give in_box=0.
  - Register: in_box, cell-relative cx/cy, the selected digit's BCD nibble from the current score, and pix_valid_in.
- Stage 2:
  - Decode the nibble to segments a..g, active-high.
  - Segment hit rectangles, with S=SCALE, half-open [lo,hi):
    - a: cx in [5S,21S), cy in [0,5S)
    - b: cx in [21S,26S), cy in [5S,17S)
    - c: cx in [21S,26S), cy in [22S,34S)
    - d: cx in [5S,21S), cy in [34S,39S)
    - e: cx in [0,5S), cy in [22S,34S)
    - f: cx in [0,5S), cy in [5S,17S)
    - g: cx in [5S,21S), cy in [17S,22S)
  - display is registered: OR of (hit & lit) & in_box & valid.
- Nibbles 10..15 cannot occur from the counter, but the decoder still defines them as blank.
- A score change between stages does not corrupt a pixel: the nibble is captured in stage 1.
- Reset mid-frame clears the pipeline. display is 0 for 2 cycles after reset deasserts.

Optional Feature:
- Macro SCORE_FLASH_EN.
- When defined:
  - Any score change (inc that modifies the score, or clr) loads the flash counter with FLASH_FRAMES.
  - Each frame_tick decrements it while nonzero.
  - While nonzero, display is forced to 0 on frames where counter bit 2 is 1 (blink period of 8 frames).
  - A new change during flashing reloads the counter.
- When undefined: frame_tick is ignored, no counter is instantiated, and display follows segments only.

Decomposition:
- Shared package pong_pkg holds:
  - segment index constants SEG_A..SEG_G (0..6)
  - geometry constants SEG_THICK=5, SEG_LEN=16, CELL_W=26, CELL_H=39
  - the bcd_t 4-bit typedef
- Sub-module bcd_seg7_decode: combinational, BCD nibble in, 7-bit active-high segments out. Reused by any future text/number renderer.

Test Plan:
- Reset: hold reset 3 cycles -> score=0, max_reached=0, display=0, pix_valid_out=0.
- Segment a of digit 0, SCALE=1, start=(100,50), score 00: pixel (105,50) valid -> display=1 exactly 2 clocks later. Pixel (110,69) (segment g) -> 0.
- Digit 1 and gap, DIGITS=2: pixel (100+34+21, 50+5), segment b of digit 1 on '0' -> 1. Pixel (128,55) in the gap -> 0.
- Saturation: 99 score_inc pulses -> score=0x99, max_reached=1. A 100th pulse -> still 0x99. score_inc with score_clr in the same cycle -> score=0x00, max_reached=0.
- No wrap: start_x=1000, start_y=0, pixel (5,10) -> display=0. Pixel (1005,0) -> 1.
- SCORE_FLASH_EN build: one inc, then frame_tick pulses -> display for a lit pixel is gated off when counter bit 2 = 1. After 30 ticks it stays on permanently.
